// File: rtl/xtimer_slave.sv
// xtimer_slave: memory-mapped down-counting timer on the picoVersat data bus.
// Prescaled countdown from LOAD to 0, one-shot or auto-reload, with a
// write-1-to-clear expiry flag and a level interrupt gated by IE.
module xtimer_slave #(
  parameter int DATA_W  = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              irq
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  state_e               state_r, state_s;
  logic                 auto_r, auto_s;
  logic                 ie_r, ie_s;
  logic [PRESC_W-1:0]   presc_r, presc_s;
  logic [PRESC_W-1:0]   pcnt_r, pcnt_s;
  logic [DATA_W-1:0]    load_r, load_s;
  logic [DATA_W-1:0]    count_r, count_s;
  logic                 exp_r, exp_s;

  logic                 wr_s;
  logic                 tick_s;
  logic                 expire_s;
  logic [DATA_W-1:0]    ctrl_rd_s;
  logic [DATA_W-1:0]    status_rd_s;

  // State register and all programmable/counting state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      auto_r  <= 1'b0;
      ie_r    <= 1'b0;
      presc_r <= '0;
      pcnt_r  <= '0;
      load_r  <= '0;
      count_r <= '0;
      exp_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      auto_r  <= auto_s;
      ie_r    <= ie_s;
      presc_r <= presc_s;
      pcnt_r  <= pcnt_s;
      load_r  <= load_s;
      count_r <= count_s;
      exp_r   <= exp_s;
    end
  end

  // Next-state logic: countdown first, then software writes override it
  always_comb begin
    state_s = state_r;
    auto_s  = auto_r;
    ie_s    = ie_r;
    presc_s = presc_r;
    pcnt_s  = pcnt_r;
    load_s  = load_r;
    count_s = count_r;
    exp_s   = exp_r;

    wr_s     = sel & we;
    // >= rather than == so a PRESC lowered below pcnt still ticks at once
    tick_s   = (state_r == ST_RUN) && (pcnt_r >= presc_r);
    expire_s = tick_s && (count_r == '0);

    case (state_r)
      ST_RUN: begin
        if (tick_s) begin
          pcnt_s = '0;
          if (count_r != '0) begin
            count_s = count_r - {{(DATA_W-1){1'b0}}, 1'b1};
          end else if (auto_r) begin
            count_s = load_r;
          end else begin
            // one-shot: stop with COUNT parked at 0
            state_s = ST_IDLE;
          end
        end else begin
          pcnt_s = pcnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        pcnt_s  = pcnt_r;
        count_s = count_r;
      end
    endcase

    if (wr_s) begin
      case (addr)
        A_CTRL: begin
          auto_s  = data_in[1];
          ie_s    = data_in[2];
          presc_s = data_in[16 +: PRESC_W];
          if (data_in[0]) begin
            // only an EN 0->1 edge restarts; a rewrite in RUN keeps counting
            // and also overrides a coincident one-shot stop
            if (state_r == ST_IDLE) begin
              count_s = load_r;
              pcnt_s  = '0;
            end else begin
              count_s = count_s;
            end
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        A_LOAD: begin
          load_s = data_in;
        end
        A_STATUS: begin
          if (data_in[0]) begin
            exp_s = 1'b0;
          end else begin
            exp_s = exp_r;
          end
        end
        default: begin
          // COUNT is read-only
          count_s = count_s;
        end
      endcase
    end else begin
      load_s = load_r;
    end

    // hardware set beats a same-cycle software clear
    if (expire_s) begin
      exp_s = 1'b1;
    end else begin
      exp_s = exp_s;
    end
  end

  // Read mux: combinational, zero when not selected so it can be OR-muxed
  always_comb begin
    ctrl_rd_s               = '0;
    ctrl_rd_s[0]            = (state_r == ST_RUN);
    ctrl_rd_s[1]            = auto_r;
    ctrl_rd_s[2]            = ie_r;
    ctrl_rd_s[16 +: PRESC_W] = presc_r;
    status_rd_s             = '0;
    status_rd_s[0]          = exp_r;
    data_out                = '0;
    if (sel) begin
      case (addr)
        A_CTRL:   data_out = ctrl_rd_s;
        A_LOAD:   data_out = load_r;
        A_COUNT:  data_out = count_r;
        A_STATUS: data_out = status_rd_s;
        default:  data_out = '0;
      endcase
    end else begin
      data_out = '0;
    end
  end

  assign irq = exp_r & ie_r;

endmodule

// File: tb/tb_xtimer_slave.sv
// Directed self-checking bench for xtimer_slave.
module tb_xtimer_slave;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        irq;

  int n_checks;
  int n_errors;

  xtimer_slave #(.DATA_W(32), .PRESC_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock edge; inputs/samples live 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single-cycle write; the write edge is the posedge inside this task
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; data_in = 32'h0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    v = data_out;
    sel = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'h0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // ---- reset mid-run ----
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h0000_0005);
    repeat (3) step();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    rd_chk("rst_ctrl",   2'd0, 32'h0);
    rd_chk("rst_load",   2'd1, 32'h0);
    rd_chk("rst_count",  2'd2, 32'h0);
    rd_chk("rst_status", 2'd3, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);

    // ---- one-shot: LOAD=3, EN|IE, PRESC=0 ----
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h0000_0005);          // edge k
    rd_chk("os_cnt_k0", 2'd2, 32'd3);
    step(); rd_chk("os_cnt_k1", 2'd2, 32'd2);
    step(); rd_chk("os_cnt_k2", 2'd2, 32'd1);
    step(); rd_chk("os_cnt_k3", 2'd2, 32'd0);
    rd_chk("os_exp_k3", 2'd3, 32'd0);
    check("os_irq_k3", {31'd0, irq}, 32'h0);
    step();                           // edge k+4: expiry
    rd_chk("os_exp_k4", 2'd3, 32'd1);
    check("os_irq_k4", {31'd0, irq}, 32'h1);
    rd_chk("os_ctrl", 2'd0, 32'h0000_0004);
    repeat (20) step();
    rd_chk("os_cnt_hold", 2'd2, 32'd0);
    rd_chk("os_ctrl_hold", 2'd0, 32'h0000_0004);
    wr(2'd0, 32'h0);                  // clearing IE drops irq
    check("os_irq_ie0", {31'd0, irq}, 32'h0);
    wr(2'd3, 32'd0);                  // writing 0 keeps EXP
    rd_chk("os_w0c", 2'd3, 32'd1);
    wr(2'd3, 32'd1);
    rd_chk("os_w1c", 2'd3, 32'd0);

    // ---- auto-reload with prescaler: LOAD=1, PRESC=2 ----
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h0002_0003);          // edge k
    repeat (5) step();                // k+5
    rd_chk("ar_exp_k5", 2'd3, 32'd0);
    step();                           // k+6 expiry
    rd_chk("ar_exp_k6", 2'd3, 32'd1);
    rd_chk("ar_reload", 2'd2, 32'd1);
    check("ar_irq_ie0", {31'd0, irq}, 32'h0);
    wr(2'd3, 32'd1);                  // k+7 clear
    rd_chk("ar_clr", 2'd3, 32'd0);
    repeat (4) step();                // k+11
    rd_chk("ar_exp_k11", 2'd3, 32'd0);
    step();                           // k+12 second expiry
    rd_chk("ar_exp_k12", 2'd3, 32'd1);
    wr(2'd3, 32'd1);                  // k+13 clear
    rd_chk("ar_clr2", 2'd3, 32'd0);
    repeat (4) step();                // k+17
    wr(2'd3, 32'd1);                  // clear on expiry edge k+18
    rd_chk("w1c_collide", 2'd3, 32'd1);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'd1);

    // ---- stop / resume / LOAD change ----
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h0000_0001);          // edge k
    rd_chk("sr_start", 2'd2, 32'd10);
    repeat (3) step();                // k+3
    wr(2'd0, 32'h0);                  // stop at k+4
    rd_chk("sr_freeze", 2'd2, 32'd6);
    repeat (3) step();
    rd_chk("sr_freeze2", 2'd2, 32'd6);
    rd_chk("sr_ctrl0", 2'd0, 32'h0);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h0000_0001);          // restart
    rd_chk("sr_restart", 2'd2, 32'd2);
    step();
    rd_chk("sr_cnt1", 2'd2, 32'd1);
    wr(2'd0, 32'h0000_0001);          // rewrite EN in RUN: no reload
    rd_chk("sr_noreload", 2'd2, 32'd0);
    rd_chk("sr_ctrl_run", 2'd0, 32'h0000_0001);
    repeat (3) step();                // one-shot expiry has passed
    rd_chk("sr_ctrl_end", 2'd0, 32'h0);
    wr(2'd3, 32'd1);

    // ---- read isolation / COUNT read-only ----
    for (int a = 0; a < 4; a++) begin
      sel = 1'b0; we = 1'b0; addr = a[1:0];
      #1;
      check("iso_rd", data_out, 32'h0);
    end
    wr(2'd2, 32'hDEAD_BEEF);
    rd_chk("cnt_ro", 2'd2, 32'd0);
    rd_chk("load_keep", 2'd1, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xtimer_slave.md
# xtimer_slave

Memory-mapped down-counting timer that acts as a responder on the picoVersat data bus. It sits behind the address decoder, receives its own select line, and accepts single-cycle register writes. It returns read data combinationally through the decoder's read mux. It raises a level interrupt on expiry, in either one-shot or auto-reload mode.

## Interface
- `DATA_W`, default 32: bus data width.
- `PRESC_W`, default 16: prescaler width; sets the width of CTRL[31:16].
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sel` in 1: peripheral select from the address decoder.
- `we` in 1: write enable; a write happens when `sel & we`.
- `addr` in 2: register offset.
- `data_in` in DATA_W: write data.
- `data_out` out DATA_W: read data, combinational. It is 0 whenever `sel`=0, so it is safe to OR-mux.
- `irq` out 1: interrupt, equal to STATUS.EXP & CTRL.IE.

## Operation
- Register map:
  - 0 CTRL (RW): bit0 EN, bit1 AUTO, bit2 IE, [31:16] PRESC; other bits read 0.
  - 1 LOAD (RW): full DATA_W.
  - 2 COUNT (RO): writes are ignored.
  - 3 STATUS: bit0 EXP; writing 1 clears it, writing 0 has no effect; other bits read 0.
- Internal prescaler counter `pcnt` is PRESC_W bits wide.
- FSM states:
  - IDLE: EN=0; COUNT and `pcnt` hold.
  - RUN: EN=1.
- Start: a CTRL write that takes EN from 0 to 1 has three effects. COUNT<=LOAD, `pcnt`<=0, and the state goes to RUN.
- Same-value write: a CTRL write with EN=1 while already in RUN updates AUTO, IE and PRESC only. It does not restart the timer.
- Stop: a CTRL write with EN=0 goes to IDLE. COUNT and `pcnt` freeze and EXP is untouched.
- In RUN, every cycle:
  - If `pcnt` >= PRESC, a tick occurs and `pcnt`<=0; otherwise `pcnt`<=`pcnt`+1.
  - The >= comparison covers a PRESC that is lowered mid-run.
- On a tick with COUNT != 0: COUNT<=COUNT-1.
- On a tick with COUNT == 0 (expiry): EXP<=1, then the mode decides what follows.
  - AUTO=1: COUNT<=LOAD and the state stays RUN.
  - AUTO=0: EN<=0 and the state goes to IDLE. COUNT stays 0.
- Period from start to first expiry is (LOAD+1)*(PRESC+1) cycles. Subsequent auto-reload periods are the same.
- LOAD written during RUN does not affect the current count. It takes effect at the next reload or start.
- Simultaneous events:
  - Hardware EXP set and a software W1C in the same cycle: the set wins and EXP=1.
  - Hardware one-shot EN clear and a software CTRL write in the same cycle: the software write wins. If that write has EN=1 it is not a 0→1 edge, so there is no restart.
- `data_out`: when `sel`=1 it presents the register at `addr`, including during a write cycle, when it shows the pre-write value. When `sel`=0 it is 0.

## Timing
- Reset (async assert, sync-safe release): CTRL=0, LOAD=0, COUNT=0, `pcnt`=0, EXP=0, state IDLE, `irq`=0. `data_out` is 0 while `sel`=0.
- Writes take one cycle. A value written at edge k is readable in the cycle after edge k.
- Reads have zero wait states: `data_out` is valid in the same cycle as `sel`.
- Start at edge k: the first tick is at edge k+PRESC+1, and expiry is at edge k+(LOAD+1)(PRESC+1).
- EXP and `irq` are high in the cycle after the expiry edge. `irq` deasserts in the cycle after a W1C edge, or immediately when IE is cleared.
- Reset asserted mid-run clears all state immediately. After release the block sits in IDLE with no interrupt pending.
- COUNT never wraps: 0 is terminal or reloads, and there is no underflow to all-ones.

## Test plan
- Reset defaults: assert `rst_n`=0 mid-run, then release. Read all four registers and expect 0; `irq`=0.
- One-shot: LOAD=3, CTRL=0x0000_0005 (EN, IE, PRESC=0) written at edge k.
  - COUNT reads 3,2,1,0.
  - EXP=1 and `irq`=1 after edge k+4.
  - CTRL reads 0x4; COUNT stays 0 for the next 20 cycles.
- Auto-reload with prescaler: LOAD=1, CTRL=0x0002_0003 (EN, AUTO, PRESC=2).
  - EXP sets after edge k+6.
  - Write STATUS=1 to clear it; EXP sets again 6 cycles after the previous expiry.
- W1C collision: arrange a STATUS=1 write on the exact expiry edge. EXP must read 1 afterwards.
- Stop/resume and LOAD change:
  - LOAD=10, start, then write CTRL EN=0 after 4 cycles. COUNT freezes at 6.
  - Write LOAD=2, then EN=1. COUNT restarts at 2.
  - Rewriting EN=1 while in RUN does not reload COUNT.
- Read isolation: with `sel`=0, `data_out`=0 regardless of `addr`. A write with `addr`=2 leaves COUNT unchanged.
